// File: rtl/seq_normalizer.sv
// Multi-cycle normalizer: shifts a word toward MSB or LSB until the terminal bit is set.
// Optional NORM_FAST_EN: allows two-position steps when the top two bits are clear.
module seq_normalizer #(
    parameter int WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic [WIDTH-1:0]         data_in,
    input  logic                     direction,
    output logic                     busy,
    output logic                     done,
    output logic [WIDTH-1:0]         data_out,
    output logic [$clog2(WIDTH)-1:0] shift_amt,
    output logic                     zero
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] work_q, work_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             dir_q, dir_d;
    logic [WIDTH-1:0] data_out_q, data_out_d;
    logic [CW-1:0]    shift_amt_q, shift_amt_d;
    logic             zero_q, zero_d;

    logic terminal_bit;
    logic neighbour_bit;

    assign terminal_bit  = dir_q ? work_q[0] : work_q[WIDTH-1];
    assign neighbour_bit = dir_q ? work_q[1] : work_q[WIDTH-2];

    always_comb begin
        state_d     = state_q;
        work_d      = work_q;
        cnt_d       = cnt_q;
        dir_d       = dir_q;
        data_out_d  = data_out_q;
        shift_amt_d = shift_amt_q;
        zero_d      = zero_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    work_d  = data_in;
                    cnt_d   = '0;
                    dir_d   = direction;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (work_q == '0) begin
                    zero_d      = 1'b1;
                    data_out_d  = '0;
                    shift_amt_d = '0;
                    state_d     = DONE;
                end else if (terminal_bit) begin
                    zero_d      = 1'b0;
                    data_out_d  = work_q;
                    shift_amt_d = cnt_q;
                    state_d     = DONE;
`ifdef NORM_FAST_EN
                end else if (!neighbour_bit) begin
                    // Two clear leading bits: the word cannot terminate on a single step.
                    work_d = dir_q ? (work_q >> 2) : (work_q << 2);
                    cnt_d  = cnt_q + CW'(2);
`endif
                end else begin
                    work_d = dir_q ? (work_q >> 1) : (work_q << 1);
                    cnt_d  = cnt_q + CW'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            work_q      <= '0;
            cnt_q       <= '0;
            dir_q       <= 1'b0;
            data_out_q  <= '0;
            shift_amt_q <= '0;
            zero_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            work_q      <= work_d;
            cnt_q       <= cnt_d;
            dir_q       <= dir_d;
            data_out_q  <= data_out_d;
            shift_amt_q <= shift_amt_d;
            zero_q      <= zero_d;
        end
    end

    // Status flags decode the state register only, so no input reaches an output combinationally.
    assign busy      = (state_q != IDLE);
    assign done      = (state_q == DONE);
    assign data_out  = data_out_q;
    assign shift_amt = shift_amt_q;
    assign zero      = zero_q;

    // The neighbour bit is only consulted when two-position steps are enabled.
    logic unused_ok;
    assign unused_ok = neighbour_bit;

endmodule

// File: doc/seq_normalizer.md
# seq_normalizer

- Multi-cycle normalizer; the inverse of the combinational barrel shifter.
- Given a word, it shifts one position per cycle, zero-filled, until the leading 1 reaches the MSB (left) or the trailing 1 reaches the LSB (right).
- It reports the normalized word and the shift amount that was applied.
- It sits beside the barrel shifter in the datapath. Downstream logic feeds `shift_amt` back into the barrel shifter, with `direction` inverted, to de-normalize.

## Interface
- `WIDTH`, default 8: data width; must be ≥ 2.
- `clk`  input  1: single clock; all state changes on its rising edge.
- `rst_n`  input  1: synchronous, active-low reset.
- `start`  input  1: request. Accepted only in IDLE.
- `data_in`  input  WIDTH: word to normalize. Sampled on the accepting edge.
- `direction`  input  1: 0 = normalize toward the MSB (left shift); 1 = normalize toward the LSB (right shift). Sampled on the accepting edge.
- `busy`  output  1: high whenever state ≠ IDLE.
- `done`  output  1: one-cycle pulse; high exactly while in DONE.
- `data_out`  output  WIDTH: normalized word.
- `shift_amt`  output  $clog2(WIDTH): number of positions shifted; range 0 to WIDTH-1.
- `zero`  output  1: high if the accepted `data_in` was all zeros.

## Operation
- States: IDLE, SHIFT, DONE. Internal registers:
  - `work[WIDTH-1:0]`: the word being shifted.
  - `cnt`: positions shifted so far.
  - `dir_q`: captured `direction`.
- IDLE, `start`=1 on an edge: `work`←`data_in`, `cnt`←0, `dir_q`←`direction`, go to SHIFT. With `start`=0, stay in IDLE.
- SHIFT, evaluated every edge, first matching rule wins:
  - `work`==0: `zero`←1, `data_out`←0, `shift_amt`←0, go to DONE.
  - Terminal bit set (`work[WIDTH-1]` for `dir_q`=0, `work[0]` for `dir_q`=1): `zero`←0, `data_out`←`work`, `shift_amt`←`cnt`, go to DONE.
  - Otherwise: shift `work` by 1 toward the terminal bit, zero-filling the vacated bit; `cnt`←`cnt`+1.
- DONE: `done`=1 for one cycle; the next edge always returns to IDLE.
- `start` is ignored in SHIFT and DONE. There is no queuing.
- Back-to-back requests: `start` may be asserted in the cycle after DONE, i.e. while in IDLE.
- `data_out`, `shift_amt` and `zero` change only on the edge that enters DONE. They hold that value through IDLE until the next result.
- Overflow: `cnt` never exceeds WIDTH-1, because a nonzero word reaches its terminal bit within WIDTH-1 shifts.

## Timing
- Accepting edge = edge 0. For a nonzero word needing n shifts, the FSM enters DONE on edge n+1. `done` is high during the cycle after edge n+1.
- Zero input: `done` is high after edge 1.
- Worst-case latency is WIDTH edges (n = WIDTH-1). Throughput is one result per n+3 cycles, IDLE included.
- `busy` rises after edge 0 and falls after the edge that leaves DONE.
- Reset (`rst_n`=0 on an edge), from any state including mid-SHIFT:
  - State → IDLE.
  - `busy`=0, `done`=0, `zero`=0, `data_out`=0, `shift_amt`=0, `work`=0, `cnt`=0.
  - Any in-flight request is discarded. Reset has priority over `start`.
- Outputs are registered; there are no combinational paths from inputs to outputs.

## Configuration
- Macro: `NORM_FAST_EN`.
- Undefined: one-position steps, exactly as described in Operation.
- Defined: the SHIFT rule order becomes:
  - zero check;
  - terminal-bit check;
  - if the terminal bit and its neighbour (`work[WIDTH-2]` / `work[1]`) are both 0, shift by 2 and `cnt`+=2;
  - otherwise shift by 1 and `cnt`+=1.
- With the macro defined, final `data_out` and `shift_amt` are identical to the undefined case; only latency shrinks, to roughly n/2+2 edges.
- Interface, reset behaviour and `done`/`busy` semantics are unchanged.

## Test plan
All scenarios use WIDTH=8, macro undefined unless stated.
- `data_in`=8'h13, `direction`=0 → `data_out`=8'h98, `shift_amt`=3, `zero`=0, `done` after edge 4.
- `data_in`=8'h28, `direction`=1 → `data_out`=8'h05, `shift_amt`=3, `done` after edge 4. `data_in`=8'h80, `direction`=0 → `shift_amt`=0, `done` after edge 1.
- `data_in`=8'h00 → `zero`=1, `data_out`=0, `shift_amt`=0, `done` after edge 1. Next request with 8'h01, `direction`=0 → `data_out`=8'h80, `shift_amt`=7, `zero`=0, `done` after edge 8.
- `start` pulsed with 8'h40 while busy on 8'h01 → ignored; result remains `shift_amt`=7. Outputs hold 8'h80 / 7 through the following IDLE cycles.
- `rst_n`=0 on edge 3 of the 8'h01 run → next cycle `busy`=0 and all outputs 0. A new `start` with 8'h13 then completes normally (8'h98, 3).
- `NORM_FAST_EN` defined, 8'h01, `direction`=0 → `data_out`=8'h80, `shift_amt`=7, `done` after edge 5 (steps 2,2,2,1).
